// File: rtl/roi_luma_packer.sv
// ROI luma packer: crops a window from ITU-656 decoded fields, packs 4 luma bytes per word, buffers in a show-ahead FIFO.
// Optional build macro ROI_LUMA_SUM_EN adds a per-field luma accumulator output (oLuma_Sum / oSum_Valid).
module roi_luma_packer #(
   parameter int X_START   = 0,
   parameter int X_END     = 719,
   parameter int Y_START   = 1,
   parameter int Y_END     = 288,
   parameter int FIELD_SEL = 2,
   parameter int FIFO_AW   = 4
) (
   input  logic        iCLK_27,
   input  logic        iRST_N,
   input  logic        iEnable,
   input  logic [15:0] iYCbCr,
   input  logic        iDVAL,
   input  logic [9:0]  iTV_X,
   input  logic [9:0]  iTV_Y,
   input  logic        iField,
   output logic [31:0] oData,
   output logic        oSOF,
   output logic        oEOF,
   output logic        oValid,
   input  logic        iReady,
   output logic        oOverflow,
   output logic        oShort,
   output logic        oBusy
`ifdef ROI_LUMA_SUM_EN
   ,
   output logic [31:0] oLuma_Sum,
   output logic        oSum_Valid
`endif
);

   localparam int DEPTH = 1 << FIFO_AW;
   localparam logic [10:0] X_LO   = 11'(X_START);
   localparam logic [10:0] Y_LO   = 11'(Y_START);
   localparam logic [9:0]  X_SPAN = 10'(X_END - X_START);
   localparam logic [9:0]  Y_SPAN = 10'(Y_END - Y_START);

   typedef enum logic [1:0] {S_IDLE, S_WAIT_ROI, S_ACTIVE, S_FLUSH} state_t;

   state_t            state_q, state_d;
   logic              field_q;
   logic [1:0]        idx_q, idx_d;
   logic [3:0][7:0]   bytes_q, bytes_d;
   logic              first_q, first_d;
   logic              done_q, done_d;
   logic              wr_pend_q, wr_pend_d;
   logic [33:0]       wr_word_q, wr_word_d;
   logic              ovf_q, ovf_d;
   logic              short_q, short_d;
   logic [FIFO_AW:0]  wr_ptr_q, rd_ptr_q;
   logic [33:0]       mem_q [DEPTH];

   logic              boundary, field_match, arm, cap, flush_wr, is_eof, start_px;
   logic              in_x, in_y;
   logic [10:0]       x_off, y_off;
   logic [7:0]        luma;
   logic              fifo_wr, fifo_rd, fifo_full, fifo_empty, wr_ok, drop;
   logic [33:0]       fifo_wdata, rd_word;
   logic              unused_chroma;

   assign unused_chroma = ^iYCbCr[7:0];
   assign luma        = iYCbCr[15:8];
   assign boundary    = (iField != field_q);
   assign field_match = (FIELD_SEL == 2) || (iField == 1'(FIELD_SEL));

   // Offset-and-borrow range test keeps the compare valid when the window starts at 0.
   assign x_off    = {1'b0, iTV_X} - X_LO;
   assign y_off    = {1'b0, iTV_Y} - Y_LO;
   assign in_x     = !x_off[10] && (x_off[9:0] <= X_SPAN);
   assign in_y     = !y_off[10] && (y_off[9:0] <= Y_SPAN);
   assign start_px = iDVAL && (iTV_X == 10'(X_START)) && (iTV_Y == 10'(Y_START));
   assign is_eof   = (iTV_X == 10'(X_END)) && (iTV_Y == 10'(Y_END));

   assign fifo_empty = (wr_ptr_q == rd_ptr_q);
   assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                       (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
   assign fifo_rd    = !fifo_empty && iReady;

`ifdef ROI_LUMA_SUM_EN
   logic [31:0] acc_q, acc_d;
   logic [31:0] sum_q;
   logic        sum_vld_q;
`endif

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      bytes_d   = bytes_q;
      first_d   = first_q;
      done_d    = done_q;
      wr_pend_d = 1'b0;
      wr_word_d = wr_word_q;
      short_d   = short_q;
      arm       = 1'b0;
      cap       = 1'b0;
      flush_wr  = 1'b0;
`ifdef ROI_LUMA_SUM_EN
      acc_d     = acc_q;
`endif

      case (state_q)
         S_IDLE: begin
            if (boundary && iEnable && field_match) begin
               arm     = 1'b1;
               state_d = S_WAIT_ROI;
            end
         end
         S_WAIT_ROI: begin
            // done_q: previous field finished cleanly, so this boundary re-arms rather than flushes.
            if (boundary) begin
               if (done_q) begin
                  if (iEnable && field_match) arm = 1'b1;
                  else                        state_d = S_IDLE;
               end else begin
                  state_d = S_FLUSH;
                  short_d = 1'b1;
               end
            end else if (!done_q && start_px) begin
               cap     = 1'b1;
               state_d = S_ACTIVE;
            end
         end
         S_ACTIVE: begin
            if (boundary) begin
               state_d = S_FLUSH;
               short_d = 1'b1;
            end else if (iDVAL && in_x && in_y) begin
               cap = 1'b1;
            end
         end
         S_FLUSH: begin
            if (!fifo_full) begin
               flush_wr = 1'b1;
               state_d  = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase

      if (cap) begin
         bytes_d[idx_q] = luma;
         idx_d          = idx_q + 2'd1;
`ifdef ROI_LUMA_SUM_EN
         acc_d          = acc_q + 32'(luma);
`endif
         if (idx_q == 2'd3) begin
            wr_pend_d = 1'b1;
            wr_word_d = {first_q, is_eof, luma, bytes_q[2], bytes_q[1], bytes_q[0]};
            first_d   = 1'b0;
            bytes_d   = '0;
            if (is_eof) begin
               if (iEnable) begin
                  state_d = S_WAIT_ROI;
                  done_d  = 1'b1;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
      end

      if (arm) begin
         idx_d   = 2'd0;
         bytes_d = '0;
         first_d = 1'b1;
         done_d  = 1'b0;
         short_d = 1'b0;
`ifdef ROI_LUMA_SUM_EN
         acc_d   = '0;
`endif
      end
   end

   assign fifo_wr    = wr_pend_q || flush_wr;
   assign fifo_wdata = wr_pend_q ? wr_word_q : {first_q, 1'b1, bytes_q};
   assign wr_ok      = fifo_wr && (!fifo_full || fifo_rd);
   assign drop       = fifo_wr && fifo_full && !fifo_rd;

   always_comb begin
      ovf_d = arm ? 1'b0 : ovf_q;
      if (drop) ovf_d = 1'b1;
   end

   always_ff @(posedge iCLK_27 or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q   <= S_IDLE;
         field_q   <= 1'b0;
         idx_q     <= 2'd0;
         bytes_q   <= '0;
         first_q   <= 1'b0;
         done_q    <= 1'b0;
         wr_pend_q <= 1'b0;
         wr_word_q <= '0;
         ovf_q     <= 1'b0;
         short_q   <= 1'b0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
      end else begin
         state_q   <= state_d;
         field_q   <= iField;
         idx_q     <= idx_d;
         bytes_q   <= bytes_d;
         first_q   <= first_d;
         done_q    <= done_d;
         wr_pend_q <= wr_pend_d;
         wr_word_q <= wr_word_d;
         ovf_q     <= ovf_d;
         short_q   <= short_d;
         if (wr_ok)   wr_ptr_q <= wr_ptr_q + 1'b1;
         if (fifo_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
      end
   end

   always_ff @(posedge iCLK_27) begin
      if (wr_ok) mem_q[wr_ptr_q[FIFO_AW-1:0]] <= fifo_wdata;
   end

   // Head entry is only overwritten after it is popped, so outputs hold while stalled.
   assign rd_word   = mem_q[rd_ptr_q[FIFO_AW-1:0]];
   assign oValid    = !fifo_empty;
   assign oData     = fifo_empty ? 32'd0 : rd_word[31:0];
   assign oEOF      = !fifo_empty && rd_word[32];
   assign oSOF      = !fifo_empty && rd_word[33];
   assign oOverflow = ovf_q;
   assign oShort    = short_q;
   assign oBusy     = (state_q != S_IDLE);

`ifdef ROI_LUMA_SUM_EN
   always_ff @(posedge iCLK_27 or negedge iRST_N) begin
      if (!iRST_N) begin
         acc_q     <= '0;
         sum_q     <= '0;
         sum_vld_q <= 1'b0;
      end else begin
         acc_q     <= acc_d;
         sum_vld_q <= 1'b0;
         if (fifo_wr && fifo_wdata[32]) begin
            sum_q     <= acc_q;
            sum_vld_q <= 1'b1;
         end
      end
   end

   assign oLuma_Sum  = sum_q;
   assign oSum_Valid = sum_vld_q;
`endif

endmodule

// File: doc/roi_luma_packer.md
Name: roi_luma_packer

Overview:
- Sits directly downstream of the ITU-656 decoder and consumes its 4:2:2 pixel stream, pixel coordinates and field flag.
- Crops a rectangular region of interest (ROI) from each selected field and keeps luma only.
- Packs four luma bytes into one 32-bit word.
- Buffers the words in a small FIFO with a valid/ready output toward the frame-store writer.
- Marks the first and last word of each field.

Parameters:
X_START, 0, first ROI column (pixel index 0..719)
X_END, 719, last ROI column; (X_END-X_START+1) must be a multiple of 4
Y_START, 1, first ROI line (field line counter value)
Y_END, 288, last ROI line
FIELD_SEL, 2, 0 = capture field 0 only, 1 = field 1 only, 2 = both fields
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words

Ports:
iCLK_27  in  1  pixel clock, 27 MHz
iRST_N  in  1  asynchronous active-low reset
iEnable  in  1  capture enable, sampled only at field boundaries
iYCbCr  in  16  decoded pixel; [15:8] = Y, [7:0] = Cb/Cr
iDVAL  in  1  pixel valid strobe
iTV_X  in  10  pixel column of the current iYCbCr
iTV_Y  in  10  line number within the field
iField  in  1  field flag
oData  out  32  packed luma; byte0 = leftmost pixel in [7:0]
oSOF  out  1  qualifies oData: first word of a field
oEOF  out  1  qualifies oData: last word of a field
oValid  out  1  output word available
iReady  in  1  consumer accepts the word when oValid && iReady
oOverflow  out  1  sticky: a word was dropped because the FIFO was full
oShort  out  1  sticky: field ended before the ROI end pixel arrived
oBusy  out  1  high in WAIT_ROI, ACTIVE and FLUSH

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, byte index 0, sticky flags 0.
- Field boundary: any change of iField between consecutive clock cycles.
- IDLE -> WAIT_ROI:
  - transition happens on a field boundary when iEnable = 1 and the new iField matches FIELD_SEL (FIELD_SEL = 2 matches either value);
  - at this transition, clear oOverflow and oShort, set byte index to 0, and arm the first-word flag.
- WAIT_ROI -> ACTIVE: on the first iDVAL pixel with iTV_X = X_START and iTV_Y = Y_START. That pixel is captured.
- Capture in ACTIVE: an iDVAL pixel is captured only when X_START <= iTV_X <= X_END and Y_START <= iTV_Y <= Y_END. All other pixels are ignored.
- Packing:
  - a captured Y goes into byte[index] and the index increments, wrapping 3 -> 0;
  - when index 3 is filled, the word is written to the FIFO in the next cycle;
  - oSOF = 1 on the first word after arming; oEOF = 1 on the word containing pixel (X_END, Y_END);
  - after the EOF word is written: WAIT_ROI if iEnable = 1, otherwise IDLE.
- Field boundary in WAIT_ROI or ACTIVE (short field):
  - go to FLUSH and set oShort;
  - FLUSH writes one word {zero-padded partial bytes} with oEOF = 1. oSOF on that word is 1 if no word has been written yet this field;
  - FLUSH holds until the FIFO is not full, then writes the word and goes to IDLE;
  - the boundary that caused FLUSH does not also arm a new capture.
- FIFO:
  - show-ahead; stores 34 bits = {SOF, EOF, data}; oValid = !empty;
  - latency: 4th pixel captured at cycle N, word written at N+1, oValid = 1 at N+2;
  - simultaneous write and read when full: both succeed and no data is lost;
  - write when full with no read: word dropped and oOverflow set. If the dropped word carried EOF, EOF is lost (the verifier checks oOverflow);
  - pointers are FIFO_AW+1 bits; full/empty from the MSB compare.
- oData, oSOF and oEOF stay stable while oValid && !iReady.
- iEnable deasserted mid-field: the current field completes normally, then the block returns to IDLE.
- Reset mid-operation: asynchronous return to the reset state; FIFO contents discarded.

Optional Feature:
- Macro: ROI_LUMA_SUM_EN.
- When defined:
  - adds output oLuma_Sum [31:0] and strobe oSum_Valid;
  - a 32-bit accumulator adds every captured Y and clears when a capture is armed;
  - on the EOF word write (normal or FLUSH), oLuma_Sum latches the accumulator including the final pixel, and oSum_Valid pulses for 1 cycle;
  - reset value 0.
- When not defined: neither port nor accumulator exists; everything else is identical.

Test Plan:
- ROI X 0..7, Y 1..2, FIELD_SEL 2, Y = 8'h10 + pixel index, iReady = 1 -> 4 words:
  - 32'h13121110 with SOF;
  - 32'h17161514;
  - then line 2 words;
  - last word EOF; oValid 2 cycles after each 4th pixel.
- Pixels outside the ROI and iDVAL = 0 cycles interleaved -> same 4 words, no extra words.
- FIELD_SEL 1, fields alternate 0/1 -> words produced only during field 1; oBusy low throughout field 0.
- iReady held 0, 2**FIFO_AW+1 words generated -> oOverflow = 1, first 16 words intact and in order. Releasing iReady drains exactly 16 words.
- Field toggles after 6 ROI pixels with Y = 1..6 -> oShort = 1; words 32'h04030201 (SOF) then 32'h00000605 (EOF); state IDLE.
- ROI_LUMA_SUM_EN defined, ROI of 8 pixels all Y = 8'h20 -> oLuma_Sum = 32'h100 with a 1-cycle oSum_Valid at the EOF write. Reset asserted mid-field -> all outputs 0 immediately.
